// File: rtl/modmul_issue_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// modmul_issue_if: operand stream, multiplier bus and result stream
// Revision: 1.0
// ----------------------------------------------------------------------
interface modmul_issue_if #(
  parameter int P_WIDTH = 256,
  parameter int TAG_W   = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [P_WIDTH-1:0] in_a;
  logic [P_WIDTH-1:0] in_b;
  logic [TAG_W-1:0]   in_tag;

  logic [P_WIDTH-1:0] mm_a;
  logic [P_WIDTH-1:0] mm_b;
  logic               mm_reset;
  logic               mm_enable;
  logic               mm_done;
  logic [P_WIDTH-1:0] mm_r;

  logic               out_valid;
  logic               out_ready;
  logic [P_WIDTH-1:0] out_r;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    input  in_valid, in_a, in_b, in_tag,
    output in_ready,
    output mm_a, mm_b, mm_reset, mm_enable,
    input  mm_done, mm_r,
    output out_valid, out_r, out_tag,
    input  out_ready
  );

  modport slave (
    output in_valid, in_a, in_b, in_tag,
    input  in_ready,
    input  mm_a, mm_b, mm_reset, mm_enable,
    output mm_done, mm_r,
    input  out_valid, out_r, out_tag,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/modmul_issue.sv
`default_nettype none
// ----------------------------------------------------------------------
// modmul_issue: queued, in-order issue/collect wrapper for a modular multiplier
// Revision: 1.0
// ----------------------------------------------------------------------
module modmul_issue #(
  parameter int P_WIDTH = 256,
  parameter int TAG_W   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  modmul_issue_if.master   bus,
  output logic             err_timeout,
  output logic [31:0]      busy_cycles
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [P_WIDTH-1:0] r_mem_a   [DEPTH];
  logic [P_WIDTH-1:0] r_mem_b   [DEPTH];
  logic [TAG_W-1:0]   r_mem_tag [DEPTH];
  logic [c_aw-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]      r_count;
  logic               r_live;
  logic [c_cw-1:0]    r_run_cnt;
  logic [P_WIDTH-1:0] r_mm_a, r_mm_b, r_out_r;
  logic [TAG_W-1:0]   r_op_tag, r_out_tag;
  logic               r_out_valid;
  logic               w_full, w_empty, w_in_ready, w_push, w_pop, w_timeout, w_finish;

  assign w_full     = (r_count == (c_aw+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  // r_live keeps the queue closed until the first clock after reset release
  assign w_in_ready = r_live && !w_full;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_timeout  = (r_run_cnt == c_cw'(TIMEOUT - 1));
  assign w_finish   = (r_state == RUN) && (bus.mm_done || w_timeout);

  assign bus.in_ready  = w_in_ready;
  assign bus.mm_a      = r_mm_a;
  assign bus.mm_b      = r_mm_b;
  assign bus.mm_reset  = (r_state == LOAD);
  assign bus.mm_enable = (r_state == RUN);
  assign bus.out_valid = r_out_valid;
  assign bus.out_r     = r_out_r;
  assign bus.out_tag   = r_out_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_pop  = 1'b1;
        w_next = LOAD;
      end
      LOAD: w_next = RUN;
      RUN:  if (bus.mm_done || w_timeout) w_next = HOLD;
      HOLD: if (bus.out_ready) begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = LOAD;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= bus.in_a;
      r_mem_b[r_wr_ptr]   <= bus.in_b;
      r_mem_tag[r_wr_ptr] <= bus.in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_run_cnt   <= '0;
      r_mm_a      <= '0;
      r_mm_b      <= '0;
      r_op_tag    <= '0;
      r_out_r     <= '0;
      r_out_tag   <= '0;
      r_out_valid <= 1'b0;
      err_timeout <= 1'b0;
      busy_cycles <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_mm_a   <= r_mem_a[r_rd_ptr];
        r_mm_b   <= r_mem_b[r_rd_ptr];
        r_op_tag <= r_mem_tag[r_rd_ptr];
      end

      if (r_state == LOAD) begin
        r_run_cnt <= '0;
      end else if (r_state == RUN) begin
        r_run_cnt   <= r_run_cnt + 1'b1;
        busy_cycles <= busy_cycles + 32'd1;
      end

      // a done in the same cycle as the timeout is a valid result
      if (w_finish) begin
        r_out_valid <= 1'b1;
        r_out_r     <= bus.mm_done ? bus.mm_r : '0;
        r_out_tag   <= r_op_tag;
        if (!bus.mm_done) err_timeout <= 1'b1;
      end else if (r_state == HOLD && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_modmul_issue.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_modmul_issue: directed + randomized bench with multiplier model and scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------
module tb_modmul_issue;
  localparam int     PW   = 32;
  localparam int     TW   = 8;
  localparam int     D    = 4;
  localparam int     TO   = 16;
  localparam longint PMOD = 65521;

  typedef struct packed {
    logic [PW-1:0] r;
    logic [TW-1:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_timeout;
  logic [31:0] busy_cycles;

  modmul_issue_if #(.P_WIDTH(PW), .TAG_W(TW)) bus ();

  modmul_issue #(.P_WIDTH(PW), .TAG_W(TW), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .err_timeout (err_timeout),
    .busy_cycles (busy_cycles)
  );

  always #5 clk = ~clk;

  // multiplier model: result after lat enabled cycles, lat==0 never finishes
  int   lat = 10;
  logic spur = 1'b0;
  int   run_cnt = 0;
  always @(posedge clk) begin
    if (bus.mm_reset)       run_cnt <= 0;
    else if (bus.mm_enable) run_cnt <= run_cnt + 1;
  end
  assign bus.mm_done = spur || (bus.mm_enable && lat > 0 && run_cnt == lat - 1);
  assign bus.mm_r    = PW'((64'(bus.mm_a) * 64'(bus.mm_b)) % PMOD);

  int n_rst = 0, n_en = 0, n_both = 0;
  always @(posedge clk) begin
    if (bus.mm_reset) n_rst <= n_rst + 1;
    if (bus.mm_enable) n_en <= n_en + 1;
    if (bus.mm_reset && bus.mm_enable) n_both <= n_both + 1;
  end

  int          checks = 0, failures = 0;
  exp_t        q[$];
  longint      exp_busy = 0;
  logic [PW-1:0] ra, rb;
  logic [TW-1:0] rt;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [TW-1:0] t);
    int   n = 0;
    exp_t e;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_tag = t;
    while (!bus.in_ready && n < 300) begin @(negedge clk); n++; end
    check("push_wait", 64'(n < 300), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    e.tag = t;
    e.r   = (lat >= 1 && lat <= TO) ? PW'((64'(a) * 64'(b)) % PMOD) : '0;
    exp_busy += (lat >= 1 && lat <= TO) ? lat : TO;
    q.push_back(e);
  endtask

  task automatic pop_out(input string name);
    int   n = 0;
    exp_t e;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && n < 300) begin @(negedge clk); n++; end
    check({name, "_valid"}, 64'(bus.out_valid), 1);
    check({name, "_pending"}, 64'(q.size() > 0), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check({name, "_r"}, 64'(bus.out_r), 64'(e.r));
      check({name, "_tag"}, 64'(bus.out_tag), 64'(e.tag));
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    int n;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    bus.out_ready = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 0);
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_out_r", 64'(bus.out_r), 0);
    check("rst_out_tag", 64'(bus.out_tag), 0);
    check("rst_mm_reset", 64'(bus.mm_reset), 0);
    check("rst_mm_enable", 64'(bus.mm_enable), 0);
    check("rst_mm_a", 64'(bus.mm_a), 0);
    check("rst_mm_b", 64'(bus.mm_b), 0);
    check("rst_err", 64'(err_timeout), 0);
    check("rst_busy", 64'(busy_cycles), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 1);

    // single operation and issue latency
    lat = 10;
    push(32'd3, 32'd5, 8'h11);
    check("lat_no_early_reset", 64'(bus.mm_reset), 0);
    @(negedge clk);
    check("lat_mm_reset", 64'(bus.mm_reset), 1);
    check("lat_mm_enable_low", 64'(bus.mm_enable), 0);
    check("lat_mm_a", 64'(bus.mm_a), 3);
    check("lat_mm_b", 64'(bus.mm_b), 5);
    pop_out("single");
    check("single_rst_pulses", 64'(n_rst), 1);
    check("single_en_cycles", 64'(n_en), 10);
    check("single_busy", 64'(busy_cycles), 10);
    check("single_err", 64'(err_timeout), 0);

    // fill the queue behind a result held by backpressure
    for (int i = 0; i < 5; i++) push(PW'($urandom % PMOD), PW'($urandom % PMOD), TW'(8'h21 + i));
    check("fill_in_ready_low", 64'(bus.in_ready), 0);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    check("bp_valid", 64'(bus.out_valid), 1);
    check("bp_r", 64'(bus.out_r), 64'(q[0].r));
    check("bp_tag", 64'(bus.out_tag), 64'(q[0].tag));
    check("bp_no_new_reset", 64'(n_rst), 2);
    check("bp_in_ready_low", 64'(bus.in_ready), 0);
    pop_out("drain0");
    check("b2b_load", 64'(bus.mm_reset), 1);
    for (int i = 1; i < 5; i++) pop_out("drain");

    // randomized latencies, first one lands on the timeout cycle
    for (int i = 0; i < 6; i++) begin
      lat = (i == 0) ? TO : int'($urandom_range(1, TO));
      ra = PW'($urandom % PMOD); rb = PW'($urandom % PMOD); rt = TW'($urandom);
      push(ra, rb, rt);
      pop_out("rand");
    end
    check("collision_no_err", 64'(err_timeout), 0);

    // done while idle is ignored
    spur = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_no_valid", 64'(bus.out_valid), 0);
    check("spur_busy", 64'(busy_cycles), 64'(exp_busy));
    spur = 1'b0;
    @(negedge clk);

    // timeout, then a normal operation
    lat = 0;
    push(32'd7, 32'd9, 8'h5a);
    n = 0;
    while (!err_timeout && n < 100) begin @(negedge clk); n++; end
    check("to_err", 64'(err_timeout), 1);
    check("to_busy", 64'(busy_cycles), 64'(exp_busy));
    check("to_enable_off", 64'(bus.mm_enable), 0);
    pop_out("timeout");
    lat = 5;
    push(PW'($urandom % PMOD), PW'($urandom % PMOD), 8'h66);
    pop_out("after_to");
    check("to_sticky", 64'(err_timeout), 1);

    // reset while running with three queued
    lat = 0;
    for (int i = 0; i < 4; i++) push(PW'($urandom % PMOD), PW'($urandom % PMOD), TW'(8'h70 + i));
    @(negedge clk);
    check("pre_rst_running", 64'(bus.mm_enable), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 0);
    check("mid_rst_enable", 64'(bus.mm_enable), 0);
    check("mid_rst_mm_reset", 64'(bus.mm_reset), 0);
    check("mid_rst_mm_a", 64'(bus.mm_a), 0);
    check("mid_rst_busy", 64'(busy_cycles), 0);
    check("mid_rst_err", 64'(err_timeout), 0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 0);
    q.delete();
    exp_busy = 0;
    @(negedge clk);
    rst_n = 1'b1;
    n = n_rst;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("post_rst_no_valid", 64'(seen), 0);
    check("post_rst_no_issue", 64'(n_rst), 64'(n));
    lat = 4;
    push(32'd100, 32'd200, 8'h99);
    pop_out("post_rst");
    check("post_rst_busy", 64'(busy_cycles), 64'(exp_busy));
    check("never_reset_and_enable", 64'(n_both), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
